seq_detector_param: RTL and testbench
=====================================

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 SHALL have parameter N, default 8: maximum pattern length in bits, legal range 2..32.
REQ-002 SHALL have parameter CNT_W, default 8: width of the match counter.
REQ-003 SHALL have parameter DEF_PATTERN, default 8'b0000_0101 (N bits): pattern loaded at reset.
REQ-004 SHALL have parameter DEF_LEN, default 3: pattern length loaded at reset.
REQ-005 SHALL have port clk  input  1: single clock; all logic updates on its rising edge.
REQ-006 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-007 SHALL have port din  input  1: serial data bit.
REQ-008 SHALL have port din_valid  input  1: din is sampled only when din_valid=1.
REQ-009 SHALL have port load  input  1: loads a new pattern and length.
REQ-010 SHALL have port pattern_in  input  N: new pattern; bit [len-1] is the first bit received, bit [0] the last.
REQ-011 SHALL have port len_in  input  $clog2(N+1): new pattern length.
REQ-012 SHALL have port overlap_en  input  1: 1 = overlapping detection, 0 = non-overlapping.
REQ-013 SHALL have port dout  output  1: registered one-cycle match pulse.
REQ-014 SHALL have port match_count  output  CNT_W: saturating count of matches.

Function
REQ-015 SHALL hold internal registers: hist (N bits), fill (0..N, valid bits in hist), pat_reg (N bits), len_reg (1..N).
REQ-016 SHALL, on a cycle with din_valid=1 and load=0, shift hist <= {hist[N-2:0], din} and set fill <= min(fill+1, N).
REQ-017 SHALL leave hist and fill unchanged on a cycle with din_valid=0.
REQ-018 SHALL detect a match when, after the shift, fill >= len_reg and the low len_reg bits of hist equal the low len_reg bits of pat_reg; pat_reg bits at or above len_reg are ignored.
REQ-019 SHALL assert dout=1 in the cycle after the completing bit is sampled, for exactly one cycle per match; dout=0 otherwise.
REQ-020 SHALL increment match_count by 1 per match and saturate at 2^CNT_W-1, never wrapping.
REQ-021 SHALL, when overlap_en=1, keep the history after a match, so the suffix of a match can start the next match.
REQ-022 SHALL, when overlap_en=0, clear fill to 0 in the matching cycle, so the next match needs len_reg fresh valid bits.
REQ-023 SHALL sample overlap_en each cycle; a change takes effect on the next sampled bit.
REQ-024 SHALL, on load=1, set pat_reg <= pattern_in and len_reg <= clamp(len_in).
REQ-025 SHALL define clamp(len_in) as: 0 -> 1; values above N -> N; otherwise len_in.
REQ-026 SHALL, on load=1, also clear fill and match_count to 0 and drive dout=0 on the next cycle.
REQ-027 SHALL ignore din_valid on a load cycle, so no bit is shifted.
REQ-028 SHALL give load priority over din_valid, and rst priority over both.
REQ-029 SHALL expose two conceptual states: FILL (fill < len_reg, no match possible) and ARMED (fill >= len_reg).
REQ-030 SHALL move FILL->ARMED when fill reaches len_reg.
REQ-031 SHALL move ARMED->FILL on a non-overlap match, on load, or on rst.

Reset
REQ-032 SHALL, on rst=1 at a clock edge, set hist=0, fill=0, dout=0 and match_count=0.
REQ-033 SHALL, on rst=1 at a clock edge, set pat_reg=DEF_PATTERN and len_reg=clamp(DEF_LEN).
REQ-034 SHALL let rst asserted mid-stream discard all partial history; no match may complete on bits sampled before the reset.

Verification
REQ-035 Reset defaults, overlap_en=1, valid din 1,0,1,0,1 -> dout pulses one cycle after bits 3 and 5; match_count=2.
REQ-036 Same stream, overlap_en=0 -> single pulse after bit 3; match_count=1.
REQ-037 load with pattern_in=8'h0D, len_in=4, overlap_en=1, then din 1,1,0,1,1,0,1 -> pulses after bits 4 and 7; match_count=2; load with len_in=0 -> len_reg=1.
REQ-038 din 1, then a din_valid=0 cycle carrying din=0, then 0, 1 (all else valid) -> one match, proving invalid cycles do not shift.
REQ-039 CNT_W=2, seven overlapping matches of 101 -> match_count sticks at 3; dout still pulses 7 times.
REQ-040 din 1,0, then rst for one cycle, then 1 -> no pulse; after reset, 1,0,1 -> one pulse; pattern back to DEF_PATTERN.

Source files
------------

// File: rtl/seq_detector_param.sv
// Serial pattern detector with runtime-loadable pattern/length and overlap control.
// Latency: dout pulses one cycle after the completing bit; no backpressure (din accepted whenever din_valid).
module seq_detector_param #(
   parameter int             N           = 8,
   parameter int             CNT_W       = 8,
   parameter logic [N-1:0]   DEF_PATTERN = N'(8'b0000_0101),
   parameter int             DEF_LEN     = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     din,
   input  logic                     din_valid,
   input  logic                     load,
   input  logic [N-1:0]             pattern_in,
   input  logic [$clog2(N+1)-1:0]   len_in,
   input  logic                     overlap_en,
   output logic                     dout,
   output logic [CNT_W-1:0]         match_count
);

   localparam int             LW  = $clog2(N+1);
   localparam logic [LW-1:0]  N_L = LW'(N);

   function automatic logic [LW-1:0] clamp_len(input logic [31:0] v);
      if (v == 32'd0)
         return LW'(1);
      else if (v > 32'(N))
         return N_L;
      else
         return v[LW-1:0];
   endfunction

   typedef enum logic {FILL, ARMED} state_t;

   state_t            state, state_nxt;
   logic [N-1:0]      hist, hist_nxt;
   logic [LW-1:0]     fill, fill_nxt;
   logic [N-1:0]      pat_reg, pat_nxt;
   logic [LW-1:0]     len_reg, len_nxt;
   logic              dout_nxt;
   logic [CNT_W-1:0]  cnt_nxt;

   logic [N-1:0]      mask;
   logic [N-1:0]      shifted;
   logic [LW-1:0]     fill_inc;
   logic              armed_after_shift;
   logic              hit;

   // The oldest history bit shifts out without ever being compared.
   logic              unused_hist_msb;
   assign unused_hist_msb = hist[N-1];

   always_comb begin
      mask = '0;
      for (int i = 0; i < N; i++)
         mask[i] = (i < int'(len_reg));

      shifted  = {hist[N-2:0], din};
      fill_inc = (fill == N_L) ? N_L : fill + LW'(1);
      // In FILL the shift can only arm us by landing exactly on len_reg.
      armed_after_shift = (state == ARMED) || (fill_inc == len_reg);
      hit = din_valid && !load && armed_after_shift &&
            (((shifted ^ pat_reg) & mask) == '0);

      hist_nxt = hist;
      fill_nxt = fill;
      pat_nxt  = pat_reg;
      len_nxt  = len_reg;
      dout_nxt = 1'b0;
      cnt_nxt  = match_count;

      if (load) begin
         pat_nxt  = pattern_in;
         len_nxt  = clamp_len(32'(len_in));
         fill_nxt = '0;
         cnt_nxt  = '0;
      end else if (din_valid) begin
         hist_nxt = shifted;
         fill_nxt = (hit && !overlap_en) ? '0 : fill_inc;
         dout_nxt = hit;
         if (hit && (match_count != '1))
            cnt_nxt = match_count + CNT_W'(1);
      end

      state_nxt = (fill_nxt >= len_nxt) ? ARMED : FILL;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= FILL;
         hist        <= '0;
         fill        <= '0;
         pat_reg     <= DEF_PATTERN;
         len_reg     <= clamp_len(32'(DEF_LEN));
         dout        <= 1'b0;
         match_count <= '0;
      end else begin
         state       <= state_nxt;
         hist        <= hist_nxt;
         fill        <= fill_nxt;
         pat_reg     <= pat_nxt;
         len_reg     <= len_nxt;
         dout        <= dout_nxt;
         match_count <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: a default instance and a CNT_W=2 instance share stimulus.
module tb_seq_detector_param;

   logic       clk = 1'b0;
   logic       rst, din, din_valid, load, overlap_en;
   logic [7:0] pattern_in;
   logic [3:0] len_in;
   logic       dout_a, dout_b;
   logic [7:0] cnt_a;
   logic [1:0] cnt_b;

   always #5 clk = ~clk;

   seq_detector_param dut_a (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .load(load),
      .pattern_in(pattern_in), .len_in(len_in), .overlap_en(overlap_en),
      .dout(dout_a), .match_count(cnt_a)
   );

   seq_detector_param #(.CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .load(load),
      .pattern_in(pattern_in), .len_in(len_in), .overlap_en(overlap_en),
      .dout(dout_b), .match_count(cnt_b)
   );

   typedef struct {
      bit dout;
      int cnt_a;
      int cnt_b;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   pulses  = 0;

   bit [7:0] m_hist, m_pat;
   int       m_fill, m_len, m_cnt_a, m_cnt_b;
   bit       m_dout;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Reference model: evaluates one clock edge from the inputs currently driven.
   task automatic model_step();
      bit hit;
      if (rst) begin
         m_hist = 8'h00; m_fill = 0; m_pat = 8'b0000_0101; m_len = 3;
         m_cnt_a = 0; m_cnt_b = 0; m_dout = 1'b0;
      end else if (load) begin
         m_pat  = pattern_in;
         m_len  = (len_in == 0) ? 1 : (len_in > 8) ? 8 : int'(len_in);
         m_fill = 0; m_cnt_a = 0; m_cnt_b = 0; m_dout = 1'b0;
      end else if (din_valid) begin
         m_hist = {m_hist[6:0], din};
         if (m_fill < 8) m_fill++;
         hit = (m_fill >= m_len);
         for (int i = 0; i < m_len; i++)
            if (m_hist[i] != m_pat[i]) hit = 1'b0;
         m_dout = hit;
         if (hit) begin
            if (m_cnt_a < 255) m_cnt_a++;
            if (m_cnt_b < 3)   m_cnt_b++;
            if (!overlap_en)   m_fill = 0;
         end
      end else begin
         m_dout = 1'b0;
      end
      sb.push_back('{m_dout, m_cnt_a, m_cnt_b});
   endtask

   task automatic cyc(input logic r, input logic l, input logic v, input logic d);
      exp_t e;
      rst = r; load = l; din_valid = v; din = d;
      model_step();
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("dout_a", 32'(dout_a), 32'(e.dout));
      check("dout_b", 32'(dout_b), 32'(e.dout));
      check("count_a", 32'(cnt_a), 32'(e.cnt_a));
      check("count_b", 32'(cnt_b), 32'(e.cnt_b));
      pulses += int'(dout_a);
   endtask

   task automatic bit_in(input logic d);
      cyc(1'b0, 1'b0, 1'b1, d);
   endtask

   task automatic do_reset();
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_load(input logic [7:0] p, input logic [3:0] l);
      pattern_in = p;
      len_in     = l;
      cyc(1'b0, 1'b1, 1'b1, 1'b1);
   endtask

   task automatic feed(input logic [15:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--)
         bit_in(bits[i]);
   endtask

   initial begin
      rst = 1'b1; din = 1'b0; din_valid = 1'b0; load = 1'b0;
      overlap_en = 1'b1; pattern_in = 8'h00; len_in = 4'd0;

      do_reset();
      do_reset();

      // Default pattern 101, overlapping
      pulses = 0;
      feed(16'b10101, 5);
      check("ovl_pulses", 32'(pulses), 32'd2);
      check("ovl_count", 32'(cnt_a), 32'd2);

      // Same stream, non-overlapping
      do_reset();
      overlap_en = 1'b0;
      pulses = 0;
      feed(16'b10101, 5);
      check("novl_pulses", 32'(pulses), 32'd1);
      check("novl_count", 32'(cnt_a), 32'd1);

      // Loaded 4-bit pattern 1101
      overlap_en = 1'b1;
      do_load(8'h0D, 4'd4);
      pulses = 0;
      feed(16'b1101101, 7);
      check("load4_pulses", 32'(pulses), 32'd2);
      check("load4_count", 32'(cnt_a), 32'd2);

      // len_in=0 clamps to one bit; pattern bit0 = 1
      do_load(8'h0D, 4'd0);
      pulses = 0;
      feed(16'b101, 3);
      check("len0_pulses", 32'(pulses), 32'd2);

      // Invalid cycle carrying din=0 must not shift
      do_reset();
      pulses = 0;
      bit_in(1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      bit_in(1'b0);
      bit_in(1'b1);
      check("gap_pulses", 32'(pulses), 32'd1);

      // Seven overlapping matches: 2-bit counter saturates
      do_reset();
      pulses = 0;
      bit_in(1'b1);
      for (int k = 0; k < 7; k++) begin
         bit_in(1'b0);
         bit_in(1'b1);
      end
      check("sat_pulses", 32'(pulses), 32'd7);
      check("sat_count_a", 32'(cnt_a), 32'd7);
      check("sat_count_b", 32'(cnt_b), 32'd3);

      // Mid-stream reset discards history, restores default pattern
      do_load(8'h0F, 4'd4);
      pulses = 0;
      feed(16'b10, 2);
      do_reset();
      bit_in(1'b1);
      check("rst_flush_pulses", 32'(pulses), 32'd0);
      feed(16'b101, 3);
      check("rst_default_pulses", 32'(pulses), 32'd1);

      // len_in above N clamps to N: needs eight ones
      do_load(8'hFF, 4'd15);
      pulses = 0;
      feed(16'b1111111, 7);
      check("clampN_early", 32'(pulses), 32'd0);
      bit_in(1'b1);
      check("clampN_pulses", 32'(pulses), 32'd1);

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
